main_ingress_shaper: RTL and testbench

- Upstream feeder for the Main FIFO write port of the QoS interconnect.
- Accepts BW-bit words from the traffic source through a valid/ready handshake and buffers them in a DEPTH-entry internal FIFO.
- Issues one registered write per cycle into Main, gated by Main's full and almost-full (pause) flags.
- Exports packet, stall and overflow status for the conditional state machine and the testbench.

---
 rtl/main_ingress_shaper.sv | 124 ++++++++++++
 tb/tb_main_ingress_shaper.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/main_ingress_shaper.sv
// Ingress shaper in front of the Main FIFO write port: buffers source words in a
// small FIFO and issues one registered write per cycle when Main is not full or paused.
module main_ingress_shaper #(
  parameter int BW    = 6,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          enable,
  input  logic          in_valid,
  input  logic [BW-1:0] in_data,
  output logic          in_ready,
  input  logic          main_full,
  input  logic          main_pause,
  output logic          main_wr,
  output logic [BW-1:0] main_data,
  output logic [CW-1:0] pkt_count,
  output logic [CW-1:0] stall_count,
  output logic          overflow_err,
  output logic          idle,
  output logic [1:0]    fsm_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } state_t;

  // Handshake: a word transfers on a rising edge where in_valid && in_ready.
  // The source keeps in_valid and in_data stable until that happens. in_ready
  // does not depend on in_valid.

  state_t        state;
  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          issue;
  logic          push;

  assign issue     = (count != '0) && enable && !main_full && !main_pause;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign in_ready  = (count < (AW+1)'(DEPTH)) || issue;
  assign push      = in_valid && in_ready;
  assign fsm_state = state;

  always_comb begin
    count_next = count;
    if (push && !issue) begin
      count_next = count + (AW+1)'(1);
    end else if (!push && issue) begin
      count_next = count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_L) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      main_wr      <= 1'b0;
      main_data    <= '0;
      pkt_count    <= '0;
      stall_count  <= '0;
      overflow_err <= 1'b0;
      idle         <= 1'b1;
    end else begin
      count   <= count_next;
      main_wr <= issue;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (issue) begin
        rd_ptr    <= rd_ptr + AW'(1);
        main_data <= mem[rd_ptr];
      end
      if (main_wr) begin
        pkt_count <= pkt_count + CW'(1);
      end
      if (state == STALL && stall_count != '1) begin
        stall_count <= stall_count + CW'(1);
      end
      if (main_wr && main_full) begin
        overflow_err <= 1'b1;
      end
      // Only IDLE can stay IDLE, and IDLE never issues, so next main_wr is 0 there.
      idle <= (state == IDLE) && !push;

      case (state)
        IDLE: begin
          if (push) begin
            state <= SEND;
          end
        end
        SEND: begin
          if (count_next == '0) begin
            state <= IDLE;
          end else if (!issue) begin
            state <= STALL;
          end
        end
        STALL: begin
          if (issue) begin
            state <= (count_next == '0) ? IDLE : SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_ingress_shaper.sv
// Directed bench for main_ingress_shaper: hand-computed per-cycle expectations plus
// an in-order scoreboard of accepted words against every write into Main.
module tb_main_ingress_shaper;

  localparam int BW    = 6;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          enable;
  logic          in_valid;
  logic [BW-1:0] in_data;
  logic          in_ready;
  logic          main_full;
  logic          main_pause;
  logic          main_wr;
  logic [BW-1:0] main_data;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] stall_count;
  logic          overflow_err;
  logic          idle;
  logic [1:0]    fsm_state;

  logic [BW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  main_ingress_shaper #(.BW(BW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset_L(reset_L), .enable(enable),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .main_full(main_full), .main_pause(main_pause),
    .main_wr(main_wr), .main_data(main_data),
    .pkt_count(pkt_count), .stall_count(stall_count),
    .overflow_err(overflow_err), .idle(idle), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver: settle, log an accepted word, advance one edge; reset flushes the model
  task automatic cyc();
    #1;
    if (!reset_L && in_valid && in_ready) exp_q.push_back(in_data);
    @(posedge clk);
    #1;
    if (reset_L) exp_q.delete();
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (main_wr === 1'b1) begin
      if (exp_q.size() > 0) check("wr_data", main_data, exp_q.pop_front());
      else check("spurious_wr", main_wr, 0);
    end
  end

  initial begin
    int idx;
    reset_L = 1'b1; enable = 1'b1; in_valid = 1'b1; in_data = 6'h3F;
    main_full = 1'b0; main_pause = 1'b0;

    // 1: reset with in_valid held high
    cyc(); cyc();
    check("t1_wr", main_wr, 0);
    check("t1_pkt", pkt_count, 0);
    check("t1_stall", stall_count, 0);
    check("t1_ovf", overflow_err, 0);
    check("t1_idle", idle, 1);
    reset_L = 1'b0; in_valid = 1'b0;
    #1;
    check("t1_rdy", in_ready, 1);

    // 2: stream 1..8 unblocked; writes in cycles 2..9
    for (int t = 0; t < 11; t++) begin
      in_valid = (t < 8);
      in_data  = 6'(t + 1);
      cyc();
      check("t2_wr", main_wr, ((t + 1) >= 2 && (t + 1) <= 9));
    end
    check("t2_pkt", pkt_count, 8);
    check("t2_stall", stall_count, 0);
    check("t2_idle", idle, 1);

    // 3: backpressure via pause for 8 cycles, 6 words offered
    idx = 0;
    for (int t = 0; t < 17; t++) begin
      main_pause = (t < 8);
      in_valid   = (idx < 6);
      in_data    = 6'h11 + 6'(idx);
      #1;
      if (t <= 9) check("t3_rdy", in_ready, (t < 4 || t >= 8));
      if (t == 8) check("t3_stall_mid", stall_count, 6);
      if (in_valid && in_ready) idx++;
      cyc();
    end
    check("t3_pkt", pkt_count, 14);
    check("t3_stall", stall_count, 7);
    check("t3_idle", idle, 1);
    check("t3_wr", main_wr, 0);

    // 4: full buffer, then push and pop together every cycle
    for (int t = 0; t < 16; t++) begin
      main_pause = (t < 4);
      in_valid   = (t < 10);
      in_data    = 6'h21 + 6'(t);
      #1;
      if (t < 10) check("t4_rdy", in_ready, 1);
      cyc();
      check("t4_wr", main_wr, ((t + 1) >= 5 && (t + 1) <= 14));
    end
    check("t4_pkt", pkt_count, 24);
    check("t4_stall", stall_count, 10);

    // 5: main_full while a write is on the port
    main_pause = 1'b0;
    check("t5_ovf0", overflow_err, 0);
    for (int t = 0; t < 6; t++) begin
      in_valid  = (t == 0);
      in_data   = 6'h2B;
      main_full = (t == 2);
      cyc();
      check("t5_ovf", overflow_err, ((t + 1) >= 3));
    end
    main_full = 1'b0;
    check("t5_drain", exp_q.size(), 0);
    check("t5_pkt", pkt_count, 25);

    // 6: reset with 3 words queued and a write in flight
    for (int t = 0; t < 6; t++) begin
      main_pause = (t < 4);
      in_valid   = (t < 4);
      in_data    = 6'h31 + 6'(t);
      reset_L    = (t == 5);
      cyc();
      if (t == 4) begin
        check("t6_wr_pre", main_wr, 1);
        check("t6_ovf_pre", overflow_err, 1);
      end
    end
    check("t6_wr", main_wr, 0);
    check("t6_pkt", pkt_count, 0);
    check("t6_stall", stall_count, 0);
    check("t6_ovf", overflow_err, 0);
    check("t6_idle", idle, 1);
    reset_L = 1'b0; in_valid = 1'b0;
    for (int t = 0; t < 6; t++) begin
      cyc();
      check("t6_quiet", main_wr, 0);
    end
    check("t6_pkt_end", pkt_count, 0);
    check("t6_rdy", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
